// File: rtl/nios_pio_out_ex_if.sv
// Avalon-MM slave bus bundle for the nios_pio_out_ex output PIO.
// The Nios data master drives it through the master modport.
interface nios_pio_out_ex_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_pio_out_ex.sv
// Output PIO: DATA register with set/clear ports and a per-bit blink engine.
// Define NIOS_PIO_PULSE_EN to build the one-shot pulse generator at address 6.
module nios_pio_out_ex #(
  parameter int unsigned          WIDTH        = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE  = '0,
  parameter int unsigned          PERIOD_W     = 24,
  parameter logic [PERIOD_W-1:0]  PERIOD_RESET = '0
) (
  input  logic               clk,
  input  logic               reset,
  nios_pio_out_ex_if.slave   bus,
  output logic [WIDTH-1:0]   out_port
);

  typedef enum logic [2:0] {
    ADDR_DATA     = 3'd0,
    ADDR_OUT      = 3'd1,
    ADDR_BLINK_EN = 3'd2,
    ADDR_PERIOD   = 3'd3,
    ADDR_OUTSET   = 3'd4,
    ADDR_OUTCLEAR = 3'd5,
    ADDR_PULSE    = 3'd6,
    ADDR_RSVD     = 3'd7
  } addr_e;

  addr_e               addr;
  logic                wr;
  logic [WIDTH-1:0]    wd;
  logic [PERIOD_W-1:0] wd_period;
  logic                unused_wd;

  assign addr      = addr_e'(bus.address);
  assign wr        = bus.chipselect & ~bus.write_n;
  assign wd        = bus.writedata[WIDTH-1:0];
  assign wd_period = bus.writedata[PERIOD_W-1:0];
  assign unused_wd = ^bus.writedata;

  logic [WIDTH-1:0]    data_q,     data_d;
  logic [WIDTH-1:0]    blink_en_q, blink_en_d;
  logic [PERIOD_W-1:0] period_q,   period_d;
  logic [PERIOD_W-1:0] cnt_q,      cnt_d;
  logic                phase_q,    phase_d;
  logic [WIDTH-1:0]    pulse_term;

  // NOTE: every variable gets its hold value first so no path through the
  // case statement leaves it unassigned and infers a latch.
  always_comb begin
    data_d     = data_q;
    blink_en_d = blink_en_q;
    period_d   = period_q;
    if (cnt_q == period_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      phase_d = phase_q;
    end

    if (wr) begin
      case (addr)
        ADDR_DATA:     data_d     = wd;
        ADDR_BLINK_EN: blink_en_d = wd;
        ADDR_PERIOD: begin
          // A PERIOD write restarts the blink cycle and overrides a coincident wrap.
          period_d = wd_period;
          cnt_d    = '0;
          phase_d  = 1'b0;
        end
        ADDR_OUTSET:   data_d = data_q | wd;
        ADDR_OUTCLEAR: data_d = data_q & ~wd;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= RESET_VALUE;
      blink_en_q <= '0;
      period_q   <= PERIOD_RESET;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
    end else begin
      data_q     <= data_d;
      blink_en_q <= blink_en_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
    end
  end

`ifdef NIOS_PIO_PULSE_EN
  logic [WIDTH-1:0]    pulse_mask_q, pulse_mask_d;
  logic [PERIOD_W-1:0] pcnt_q,       pcnt_d;

  // pcnt counts PERIOD..0, so the mask is live for PERIOD+1 cycles.
  always_comb begin
    pulse_mask_d = pulse_mask_q;
    pcnt_d       = pcnt_q;
    if (wr && (addr == ADDR_PULSE)) begin
      pulse_mask_d = wd;
      pcnt_d       = period_q;
    end else if (pcnt_q != '0) begin
      pcnt_d = pcnt_q - 1'b1;
    end else begin
      pulse_mask_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_mask_q <= '0;
      pcnt_q       <= '0;
    end else begin
      pulse_mask_q <= pulse_mask_d;
      pcnt_q       <= pcnt_d;
    end
  end

  assign pulse_term = pulse_mask_q;
`else
  assign pulse_term = '0;
`endif

  assign out_port = (data_q & ~blink_en_q)
                  | (data_q & blink_en_q & {WIDTH{phase_q}})
                  | pulse_term;

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_DATA:     rdata = 32'(data_q);
      ADDR_OUT:      rdata = 32'(out_port);
      ADDR_BLINK_EN: rdata = 32'(blink_en_q);
      ADDR_PERIOD:   rdata = 32'(period_q);
`ifdef NIOS_PIO_PULSE_EN
      ADDR_PULSE:    rdata = 32'(pulse_mask_q);
`endif
      default: ;
    endcase
  end

  assign bus.readdata = rdata;

endmodule

// File: tb/tb_nios_pio_out_ex.sv
// Directed bench for nios_pio_out_ex (WIDTH=8, RESET_VALUE=0x5A).
// Pulse cases follow NIOS_PIO_PULSE_EN so the bench matches either build.
module tb_nios_pio_out_ex;
  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] out_port;
  int         n_checks = 0;
  int         n_pass   = 0;

  nios_pio_out_ex_if bus ();

  nios_pio_out_ex #(
    .WIDTH       (8),
    .RESET_VALUE (8'h5A),
    .PERIOD_W    (24),
    .PERIOD_RESET(24'd0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp);
    check(tag, 32'(out_port), 32'(exp));
  endtask

  // Drives at the next falling edge; returns one cycle later, after the capturing edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    check(tag, bus.readdata, exp);
  endtask

  initial begin
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // Reset asserted mid-cycle takes effect immediately.
    #1 reset = 1'b1;
    #1;
    check_out("reset_out", 8'h5A);
    read_check("reset_data", 3'd0, 32'h0000_005A);
    read_check("reset_period", 3'd3, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // DATA write: upper writedata bits ignored, old value held until the edge.
    @(negedge clk);
    bus.address    = 3'd0;
    bus.writedata  = 32'hFFFF_FFFF;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    #1;
    check_out("pre_edge_out", 8'h5A);
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    check_out("data_out", 8'hFF);
    read_check("data_rd", 3'd0, 32'h0000_00FF);
    read_check("out_rd", 3'd1, 32'h0000_00FF);
    read_check("outset_rd0", 3'd4, 32'h0);
    read_check("outclr_rd0", 3'd5, 32'h0);
    read_check("rsvd_rd0", 3'd7, 32'h0);

    // Set / clear ports and ignored addresses.
    bus_write(3'd0, 32'h0000_00A0);
    check_out("data_a0", 8'hA0);
    bus_write(3'd4, 32'h0000_000F);
    check_out("outset", 8'hAF);
    bus_write(3'd5, 32'h0000_0003);
    check_out("outclr", 8'hAC);
    read_check("setclr_rd", 3'd0, 32'h0000_00AC);
    bus_write(3'd1, 32'h0000_0000);
    check_out("wr_out_ignored", 8'hAC);
    bus_write(3'd7, 32'hFFFF_FFFF);
    check_out("wr_rsvd_ignored", 8'hAC);

    // Blink: PERIOD=3 gives 4 cycles low then 4 high on bit0.
    bus_write(3'd0, 32'h0000_0081);
    bus_write(3'd2, 32'h0000_0001);
    read_check("blink_en_rd", 3'd2, 32'h0000_0001);
    bus_write(3'd3, 32'h0000_0003);
    read_check("period_rd", 3'd3, 32'h0000_0003);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      e = 8'h80 | 8'((i / 4) % 2);
      check_out($sformatf("blink3_out[%0d]", i), e);
      read_check($sformatf("blink3_rd[%0d]", i), 3'd1, 32'(e));
      @(negedge clk);
    end

    // PERIOD=0 toggles bit0 every cycle, starting low.
    bus_write(3'd3, 32'h0000_0000);
    for (int i = 0; i < 4; i++) begin
      check_out($sformatf("blink0_out[%0d]", i), 8'h80 | 8'(i % 2));
      @(negedge clk);
    end

    // PERIOD=5 until phase=1, cnt=2; then PERIOD=1 restarts phase 0 without overrun.
    bus_write(3'd3, 32'h0000_0005);
    repeat (7) @(negedge clk);
    check_out("p5_phase1", 8'h81);
    bus_write(3'd3, 32'h0000_0001);
    for (int i = 0; i < 6; i++) begin
      check_out($sformatf("rewrite_out[%0d]", i), 8'h80 | 8'((i / 2) % 2));
      @(negedge clk);
    end

    // Pulse generator setup: blink off, DATA=0, PERIOD=2.
    bus_write(3'd2, 32'h0);
    bus_write(3'd0, 32'h0);
    bus_write(3'd3, 32'h0000_0002);
    check_out("pulse_idle", 8'h00);
`ifdef NIOS_PIO_PULSE_EN
    bus_write(3'd6, 32'h0000_0080);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = (i < 3) ? 8'h80 : 8'h00;
      check_out($sformatf("pulse_out[%0d]", i), e);
      read_check($sformatf("pulse_rd[%0d]", i), 3'd6, 32'(e));
      @(negedge clk);
    end
    // Retrigger on the second pulse cycle.
    bus_write(3'd6, 32'h0000_0080);
    check_out("retrig_first", 8'h80);
    bus_write(3'd6, 32'h0000_0001);
    for (int i = 0; i < 4; i++) begin
      check_out($sformatf("retrig_out[%0d]", i), (i < 3) ? 8'h01 : 8'h00);
      @(negedge clk);
    end
    // Retrigger on the final pulse cycle: write beats the expiry.
    bus_write(3'd6, 32'h0000_0002);
    @(negedge clk);
    bus_write(3'd6, 32'h0000_0004);
    for (int i = 0; i < 4; i++) begin
      check_out($sformatf("expiry_out[%0d]", i), (i < 3) ? 8'h04 : 8'h00);
      @(negedge clk);
    end
`else
    bus_write(3'd6, 32'h0000_0080);
    for (int i = 0; i < 3; i++) begin
      check_out($sformatf("nopulse_out[%0d]", i), 8'h00);
      read_check($sformatf("nopulse_rd[%0d]", i), 3'd6, 32'h0);
      @(negedge clk);
    end
`endif

    // Reset in the middle of a fast blink aborts everything at once.
    bus_write(3'd0, 32'h0000_0081);
    bus_write(3'd2, 32'h0000_0001);
    bus_write(3'd3, 32'h0000_0000);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check_out("midblink_reset_out", 8'h5A);
    read_check("midblink_reset_en", 3'd2, 32'h0);
    read_check("midblink_reset_period", 3'd3, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_out("post_reset_out", 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
